data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning number of 32-bit words in the backing array (power of two).
REQ-002 SHALL have parameter WBUF_DEPTH, default 4, meaning number of write-buffer entries (power of two, >=2).
REQ-003 SHALL have parameter TOHOST_ADDR, default 32'h0000_0064, meaning the byte address of the memory-mapped test-result register.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port memwrite  input  1  store request from the core, sampled at the rising edge.
REQ-007 SHALL have port aluout  input  32  byte address of the access.
REQ-008 SHALL have port writedata  input  32  store data.
REQ-009 SHALL have port drain_hold  input  1  backing array busy; when high, no buffer entry drains this cycle.
REQ-010 SHALL have port readdata  output  32  load data, combinational from the current address and state.
REQ-011 SHALL have port wbuf_count  output  $clog2(WBUF_DEPTH)+1  number of valid write-buffer entries.
REQ-012 SHALL have port wbuf_full  output  1  high when wbuf_count == WBUF_DEPTH.
REQ-013 SHALL have port overflow  output  1  sticky flag: a store was dropped.
REQ-014 SHALL have port addr_err  output  1  one-cycle registered pulse: the previous cycle's store was out of range.
REQ-015 SHALL have port tohost_valid  output  1  sticky flag: a store to TOHOST_ADDR has occurred.
REQ-016 SHALL have port tohost_data  output  32  last value stored to TOHOST_ADDR.

Function
REQ-017 SHALL ignore aluout[1:0]; word index = aluout[$clog2(DEPTH)+1:2].
REQ-018 SHALL treat an address as in range when aluout < DEPTH*4 and aluout != TOHOST_ADDR.
REQ-019 SHALL implement the write buffer as a circular FIFO with head/tail pointers that wrap modulo WBUF_DEPTH; each entry holds {index, data}.
REQ-020 SHALL enqueue an in-range store at the tail on the rising edge where memwrite=1.
REQ-021 SHALL, every cycle where wbuf_count>0 and drain_hold=0, write the head entry into the array and advance the head at the rising edge.
REQ-022 SHALL allow enqueue and drain in the same cycle; when full, a simultaneous drain frees the slot, so the store is accepted and wbuf_count is unchanged.
REQ-023 SHALL, on a store when wbuf_full=1 and drain_hold=1, drop the store and set overflow (sticky until reset), with count and pointers unchanged.
REQ-024 SHALL, for a store with aluout == TOHOST_ADDR, bypass the buffer: load tohost_data with writedata and set tohost_valid at that edge.
REQ-025 SHALL, for an out-of-range store (aluout >= DEPTH*4, not TOHOST_ADDR), drop the store and assert addr_err for exactly the following cycle.
REQ-026 SHALL drive readdata combinationally: tohost_data if aluout == TOHOST_ADDR; else 0 if out of range; else the data of the youngest valid buffer entry whose index matches; else array[index].
REQ-027 SHALL keep a head entry visible to readdata forwarding during the cycle in which it drains (the array write occurs at the edge).
REQ-028 SHALL not reflect a store presented in the current cycle on readdata until after the rising edge.
REQ-029 SHALL preserve program order: two buffered stores to the same index drain oldest first, so the array ends with the younger value.

Reset
REQ-030 SHALL, on reset assertion regardless of clock, clear head, tail and wbuf_count to 0, and overflow, addr_err, tohost_valid and tohost_data to 0.
REQ-031 SHALL clear every array word to 0 on reset.
REQ-032 SHALL discard buffered stores not yet drained when reset asserts mid-operation; none reach the array.
REQ-033 SHALL accept no store and perform no drain while reset is high.

Verification
REQ-034 SHALL pass: store 0xDEADBEEF to 0x10 with drain_hold=1, then load 0x10 -> readdata=0xDEADBEEF forwarded, wbuf_count=1; release hold -> count 0, array[4]=0xDEADBEEF.
REQ-035 SHALL pass: hold=1, stores 1,2,3,4 to 0x0,0x4,0x8,0x0 -> wbuf_full=1, load 0x0 returns 4; fifth store -> overflow=1, count stays 4; release hold -> array[0]=4 after drain.
REQ-036 SHALL pass: full buffer with hold=0 and a store to 0x20 -> store accepted, count stays 4, overflow=0.
REQ-037 SHALL pass: store 25 to 0x64 -> tohost_valid=1, tohost_data=25 next cycle, wbuf_count=0; load 0x64 returns 25.
REQ-038 SHALL pass: store to 0x400 (DEPTH=64) -> addr_err high exactly one cycle, load 0x400 returns 0, no buffer change.
REQ-039 SHALL pass: hold=1, two stores buffered, assert reset asynchronously between edges -> count=0 immediately, all flags 0, loads of both addresses return 0.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data memory responder: a word-addressed backing array behind a circular
// write buffer. Loads forward from the youngest matching buffered store, and
// stores to the tohost address go to a dedicated result register.
module data_mem_responder #(
  parameter int          DEPTH       = 64,
  parameter int          WBUF_DEPTH  = 4,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_0064
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        memwrite,
  input  logic [31:0]                 aluout,
  input  logic [31:0]                 writedata,
  input  logic                        drain_hold,
  output logic [31:0]                 readdata,
  output logic [$clog2(WBUF_DEPTH):0] wbuf_count,
  output logic                        wbuf_full,
  output logic                        overflow,
  output logic                        addr_err,
  output logic                        tohost_valid,
  output logic [31:0]                 tohost_data
);

  localparam int          AW        = $clog2(DEPTH);
  localparam int          PW        = $clog2(WBUF_DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [31:0] MEM_BYTES = 32'(DEPTH * 4);

  logic [31:0]   r_mem      [DEPTH];
  logic [AW-1:0] r_buf_idx  [WBUF_DEPTH];
  logic [31:0]   r_buf_data [WBUF_DEPTH];

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          r_addr_err;
  logic          r_tohost_valid;
  logic [31:0]   r_tohost_data;

  logic [AW-1:0] w_idx;
  logic          w_is_tohost;
  logic          w_in_range;
  logic          w_full;
  logic          w_drain;
  logic          w_store;
  logic          w_enq;
  logic          w_drop;
  logic          w_fwd_hit;
  logic [31:0]   w_fwd_data;

  // Address decode; the two low byte-offset bits never participate.
  assign w_idx       = aluout[AW+1:2];
  assign w_is_tohost = (aluout == TOHOST_ADDR);
  assign w_in_range  = (aluout < MEM_BYTES) && !w_is_tohost;

  // A drain happens whenever something is buffered and the array is free;
  // that same drain makes room for a store arriving at a full buffer.
  assign w_full  = (r_count == CW'(WBUF_DEPTH));
  assign w_drain = (r_count != '0) && !drain_hold;
  assign w_store = memwrite && w_in_range;
  assign w_enq   = w_store && (!w_full || w_drain);
  assign w_drop  = w_store && !w_enq;

  // Search buffered entries oldest to youngest so the last match wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      if ((CW'(k) < r_count) && (r_buf_idx[PW'(r_head + PW'(k))] == w_idx)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_buf_data[PW'(r_head + PW'(k))];
      end
    end
  end

  // Load data mux: tohost register, out-of-range zero, forwarding, array.
  always_comb begin
    readdata = '0;
    if (w_is_tohost)      readdata = r_tohost_data;
    else if (!w_in_range) readdata = '0;
    else if (w_fwd_hit)   readdata = w_fwd_data;
    else                  readdata = r_mem[w_idx];
  end

  // Buffer pointers, occupancy and status flags.
  // NOTE: every register below uses <= so all of them see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_overflow     <= 1'b0;
      r_addr_err     <= 1'b0;
      r_tohost_valid <= 1'b0;
      r_tohost_data  <= '0;
    end else begin
      if (w_enq)   r_tail <= r_tail + 1'b1;
      if (w_drain) r_head <= r_head + 1'b1;
      r_count    <= r_count + CW'(w_enq) - CW'(w_drain);
      r_addr_err <= memwrite && !w_in_range && !w_is_tohost;
      if (w_drop) r_overflow <= 1'b1;
      if (memwrite && w_is_tohost) begin
        r_tohost_valid <= 1'b1;
        r_tohost_data  <= writedata;
      end
    end
  end

  // Buffer payload storage, written at the tail on enqueue.
  // NOTE: no reset here; entries are only meaningful below r_count, which is reset.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_buf_idx[r_tail]  <= w_idx;
      r_buf_data[r_tail] <= writedata;
    end
  end

  // Backing array: cleared on reset, written from the head entry on drain.
  // NOTE: this memory must read as zero after reset, so it is reset as registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_drain) begin
      r_mem[r_buf_idx[r_head]] <= r_buf_data[r_head];
    end
  end

  assign wbuf_count   = r_count;
  assign wbuf_full    = w_full;
  assign overflow     = r_overflow;
  assign addr_err     = r_addr_err;
  assign tohost_valid = r_tohost_valid;
  assign tohost_data  = r_tohost_data;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed corner cases, a
// table-driven buffer sequence, and randomized traffic against a queue model.
module tb_data_mem_responder;

  localparam logic [31:0] TH = 32'h0000_0064;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] aluout = '0;
  logic [31:0] writedata = '0;
  logic        drain_hold = 1'b0;
  logic [31:0] readdata;
  logic [2:0]  wbuf_count;
  logic        wbuf_full;
  logic        overflow;
  logic        addr_err;
  logic        tohost_valid;
  logic [31:0] tohost_data;

  int n_tests = 0;
  int n_fail  = 0;

  data_mem_responder dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .aluout(aluout),
    .writedata(writedata), .drain_hold(drain_hold), .readdata(readdata),
    .wbuf_count(wbuf_count), .wbuf_full(wbuf_full), .overflow(overflow),
    .addr_err(addr_err), .tohost_valid(tohost_valid), .tohost_data(tohost_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct { int idx; logic [31:0] data; } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_mem [64];
  logic        m_ovf, m_aerr, m_thv;
  logic [31:0] m_thd;

  function automatic void model_reset();
    m_q.delete();
    for (int i = 0; i < 64; i++) m_mem[i] = '0;
    m_ovf = 0; m_aerr = 0; m_thv = 0; m_thd = '0;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int idx;
    if (a == TH) return m_thd;
    if (a >= 32'd256) return '0;
    idx = int'(a) / 4;
    for (int i = m_q.size() - 1; i >= 0; i--)
      if (m_q[i].idx == idx) return m_q[i].data;
    return m_mem[idx];
  endfunction

  function automatic void model_edge(input logic we, input logic [31:0] a,
                                     input logic [31:0] d, input logic hold);
    bit   was_full = (m_q.size() == 4);
    bit   drain    = (m_q.size() > 0) && !hold;
    ent_t e;
    m_aerr = we && (a >= 32'd256) && (a != TH);
    if (drain) begin
      e = m_q.pop_front();
      m_mem[e.idx] = e.data;
    end
    if (we && a == TH) begin
      m_thd = d;
      m_thv = 1;
    end else if (we && a < 32'd256) begin
      if (!was_full || drain) m_q.push_back('{int'(a) / 4, d});
      else m_ovf = 1;
    end
  endfunction

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        hold;
    logic [31:0] rd_addr;
    logic [31:0] exp_rd;
    int          exp_count;
    logic        exp_full;
    logic        exp_ovf;
    logic        exp_aerr;
  } vec_t;

  vec_t vecs[14];

  task automatic apply_reset();
    @(posedge clk); #1;
    memwrite = 0;
    reset = 1;
    #3;
    reset = 0;
  endtask

  initial begin
    // Fill, full-with-drain acceptance, overflow, in-order drain, bad address, tohost.
    vecs[0]  = '{1'b1, 32'h00,  32'd1, 1'b1, 32'h00,  32'd1,  1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'h04,  32'd2, 1'b1, 32'h04,  32'd2,  2, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 32'h08,  32'd3, 1'b1, 32'h08,  32'd3,  3, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 32'h00,  32'd4, 1'b1, 32'h00,  32'd4,  4, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 32'h20,  32'd6, 1'b0, 32'h20,  32'd6,  4, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 32'h0C,  32'd7, 1'b1, 32'h0C,  32'd0,  4, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 32'h00,  32'd0, 1'b0, 32'h04,  32'd2,  3, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 32'h00,  32'd0, 1'b0, 32'h08,  32'd3,  2, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 32'h00,  32'd0, 1'b0, 32'h00,  32'd4,  1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 32'h00,  32'd0, 1'b0, 32'h20,  32'd6,  0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 32'h00,  32'd0, 1'b0, 32'h00,  32'd4,  0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 32'h400, 32'd9, 1'b0, 32'h400, 32'd0,  0, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 32'h00,  32'd0, 1'b0, 32'h400, 32'd0,  0, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 32'h64,  32'd25, 1'b0, 32'h64, 32'd25, 0, 1'b0, 1'b1, 1'b0};

    // ---- reset state ----
    apply_reset();
    aluout = 32'h10; #1;
    check("reset_count", 32'(wbuf_count), 0);
    check("reset_full", 32'(wbuf_full), 0);
    check("reset_overflow", 32'(overflow), 0);
    check("reset_addr_err", 32'(addr_err), 0);
    check("reset_tohost_valid", 32'(tohost_valid), 0);
    check("reset_tohost_data", tohost_data, 0);
    check("reset_readdata", readdata, 0);

    // ---- forwarding with hold, then drain into the array ----
    drain_hold = 1; memwrite = 1; aluout = 32'h10; writedata = 32'hDEADBEEF; #1;
    check("same_cycle_store_invisible", readdata, 0);
    @(posedge clk); #1; memwrite = 0; #1;
    check("fwd_readdata", readdata, 32'hDEADBEEF);
    check("fwd_count", 32'(wbuf_count), 1);
    drain_hold = 0;
    @(posedge clk); #1;
    check("drained_count", 32'(wbuf_count), 0);
    check("drained_array_word4", readdata, 32'hDEADBEEF);

    // ---- tohost bypass ----
    memwrite = 1; aluout = TH; writedata = 32'd25;
    @(posedge clk); #1; memwrite = 0; #1;
    check("tohost_valid", 32'(tohost_valid), 1);
    check("tohost_data", tohost_data, 32'd25);
    check("tohost_count", 32'(wbuf_count), 0);
    check("tohost_readdata", readdata, 32'd25);

    // ---- asynchronous reset with buffered stores ----
    drain_hold = 1; memwrite = 1; aluout = 32'h10; writedata = 32'h1111_1111;
    @(posedge clk); #1; aluout = 32'h14; writedata = 32'h2222_2222;
    @(posedge clk); #1; memwrite = 0; #1;
    check("prereset_count", 32'(wbuf_count), 2);
    #2 reset = 1; #1;
    check("async_reset_count", 32'(wbuf_count), 0);
    check("async_reset_tohost_valid", 32'(tohost_valid), 0);
    check("async_reset_tohost_data", tohost_data, 0);
    check("async_reset_overflow", 32'(overflow), 0);
    check("async_reset_addr_err", 32'(addr_err), 0);
    aluout = 32'h10; #1;
    check("async_reset_read_10", readdata, 0);
    aluout = 32'h14; #1;
    check("async_reset_read_14", readdata, 0);
    // Stores and drains are ignored while reset stays high across an edge.
    drain_hold = 0; memwrite = 1; aluout = 32'h18; writedata = 32'h33;
    @(posedge clk); #1;
    check("in_reset_count", 32'(wbuf_count), 0);
    memwrite = 0; reset = 0;
    repeat (3) @(posedge clk);
    #1; aluout = 32'h18; #1;
    check("in_reset_store_dropped", readdata, 0);
    aluout = 32'h10; #1;
    check("post_reset_read_10", readdata, 0);

    // ---- table-driven buffer sequence ----
    apply_reset();
    foreach (vecs[i]) begin
      memwrite = vecs[i].we; aluout = vecs[i].addr;
      writedata = vecs[i].wdata; drain_hold = vecs[i].hold;
      @(posedge clk); #1;
      memwrite = 0; aluout = vecs[i].rd_addr; #1;
      check($sformatf("vec%0d_readdata", i), readdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_count", i), 32'(wbuf_count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_full", i), 32'(wbuf_full), 32'(vecs[i].exp_full));
      check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
      check($sformatf("vec%0d_addr_err", i), 32'(addr_err), 32'(vecs[i].exp_aerr));
    end
    check("table_tohost_data", tohost_data, 32'd25);

    // ---- randomized traffic against the model ----
    apply_reset();
    model_reset();
    #1;
    for (int c = 0; c < 3000; c++) begin
      logic        we, hold;
      logic [31:0] a, d;
      int          r;
      we = ($urandom_range(0, 9) < 6);
      hold = $urandom_range(0, 1) == 1;
      d = $urandom;
      r = $urandom_range(0, 19);
      if (r < 14)       a = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      else if (r == 14) a = TH + 32'($urandom_range(1, 3));
      else if (r < 18)  a = TH;
      else              a = 32'h100 + 32'($urandom_range(0, 4095));
      memwrite = we; aluout = a; writedata = d; drain_hold = hold;
      #1;
      check("rand_readdata", readdata, model_read(a));
      @(posedge clk);
      model_edge(we, a, d, hold);
      #1;
      check("rand_count", 32'(wbuf_count), 32'(m_q.size()));
      check("rand_full", 32'(wbuf_full), 32'(m_q.size() == 4));
      check("rand_overflow", 32'(overflow), 32'(m_ovf));
      check("rand_addr_err", 32'(addr_err), 32'(m_aerr));
      check("rand_tohost_valid", 32'(tohost_valid), 32'(m_thv));
      check("rand_tohost_data", tohost_data, m_thd);
    end
    // Drain everything and compare the whole array through loads.
    memwrite = 0; drain_hold = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      model_edge(1'b0, 32'h0, 32'h0, 1'b0);
    end
    #1;
    for (int i = 0; i < 64; i++) begin
      aluout = 32'(i * 4); #1;
      if (32'(i * 4) != TH) check($sformatf("final_word%0d", i), readdata, m_mem[i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
